fpu_op_sequencer: RTL and testbench
===================================

# fpu_op_sequencer

Control stage directly upstream of, and wrapped around, the `fpu` datapath. It accepts operand pairs over a valid/ready handshake and holds them stable on the FPU operand inputs for a fixed number of cycles. It then samples the FPU result, status and flag, and presents them over a second valid/ready handshake. It also keeps saturating event counters for overflow, underflow and inexact results. One operation is in flight at a time.

## Interface
Parameters:
- `LATENCY`, default 4: number of cycles the FPU needs with stable operands before its outputs are valid; legal range ≥1.
- `CNT_W`, default 16: width of each status event counter.

Ports:
- `clock100KHz`  in  1: single clock; all state is updated on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operand pair offered.
- `in_ready`  out  1: sequencer can accept an operand pair.
- `in_a`  in  32: operand A, IEEE-754 single.
- `in_b`  in  32: operand B, IEEE-754 single.
- `op_A_out`  out  32: connects to `fpu.op_A_in`.
- `op_B_out`  out  32: connects to `fpu.op_B_in`.
- `fpu_data_in`  in  32: connects from `fpu.data_out`.
- `fpu_status_in`  in  4: connects from `fpu.status_out`.
- `fpu_flags_in`  in  1: connects from `fpu.flags_out`.
- `res_valid`  out  1: result available.
- `res_ready`  in  1: consumer accepts the result.
- `res_data`  out  32: captured FPU result.
- `res_status`  out  4: captured status.
- `res_flag`  out  1: captured flag.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `cnt_clr`  in  1: synchronous clear of all event counters.
- `cnt_ovf`  out  CNT_W: count of captured results with OVERFLOW set.
- `cnt_unf`  out  CNT_W: count of captured results with UNDERFLOW set.
- `cnt_inx`  out  CNT_W: count of captured results with INEXACT set.

## Operation
- The FSM has three states: IDLE, WAIT, RESULT.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: register `in_a` into `op_A_out` and `in_b` into `op_B_out`, load the wait counter with LATENCY, and go to WAIT.
- **WAIT**
  - `in_ready`=0.
  - The wait counter decrements every cycle.
  - In the cycle where the counter equals 1: register `fpu_data_in`, `fpu_status_in` and `fpu_flags_in` into the `res_*` outputs, set `res_valid`, and go to RESULT.
- **RESULT**
  - `in_ready`=0, and `res_*` are held stable.
  - On `res_valid`&&`res_ready`: clear `res_valid` and go to IDLE. `res_data`, `res_status` and `res_flag` keep their last values.
- `op_A_out` and `op_B_out` change only on input acceptance; they hold their last operands in all other states.
- Status encoding is one-hot: bit0 EXACT, bit1 OVERFLOW, bit2 UNDERFLOW, bit3 INEXACT.
- Status and flag are passed through unmodified, including zero or multi-hot codes.
- Counters update on the capture cycle only:
  - Each counter increments if its status bit is set; several counters can increment in the same capture.
  - Each counter saturates at all-ones; no wrap-around.
  - `cnt_clr` zeroes all counters and takes priority over a same-cycle increment.
- Reset (asserted low, any state):
  - All outputs go to 0, including `op_A_out`, `op_B_out`, `res_*` and the counters.
  - The FSM returns to IDLE and any in-flight result is discarded.
  - `in_ready` is 1 after reset releases.

## Timing
- An operand pair accepted at rising edge N drives `op_A_out`/`op_B_out` from just after edge N.
- The FPU result is sampled at edge N+LATENCY, so `res_valid` rises just after edge N+LATENCY.
- With LATENCY=1, the result is sampled at the first WAIT edge.
- If the result handshake completes at edge M, `in_ready` is 1 just after edge M. The next accept can therefore happen at edge M+1.
- Best-case throughput is one operation per LATENCY+2 cycles.
- With `res_ready` held high, `res_valid` is high for exactly one cycle.
- `in_valid` while `in_ready`=0 is ignored; the offering side holds its data until accepted.
- `res_ready` while `res_valid`=0 has no effect.

## Structure
- Package `fpu_seq_pkg` contains:
  - the state enum (IDLE/WAIT/RESULT);
  - the status bit-index constants (EXACT=0, OVERFLOW=1, UNDERFLOW=2, INEXACT=3);
  - the default LATENCY and CNT_W.
- Sub-module `sat_counter`, parameterised by width, with inputs inc and clr (clr wins); it is instantiated three times.
- Top-level integration instantiates `fpu_op_sequencer` and `fpu` side by side, both on `clock100KHz`.

## Test plan
The bench drives `fpu_*` from a stub that returns pre-set values.
- **Reset:** assert `reset`=0 mid-WAIT → all outputs are 0 and `in_ready`=1 after release; no `res_valid` appears later.
- **Basic op, LATENCY=4:** offer A=0x3FC00000, B=0x40100000 at edge N, with the stub driving 0x40700000 and status 0001 → `op_A_out`=0x3FC00000 from N; `res_valid` after edge N+4 with `res_data`=0x40700000, `res_status`=0001; counters unchanged.
- **Backpressure:** `res_ready`=0 for 10 cycles → `res_*` stable and `in_ready`=0 throughout; `in_valid` pulses are ignored; raising `res_ready` completes the handshake and `in_ready`=1 the next cycle.
- **Counters:** 3 ops with status 0010, then 1 op with 1100 → `cnt_ovf`=3, `cnt_unf`=1, `cnt_inx`=1; assert `cnt_clr` on the capture cycle of a 0010 op → `cnt_ovf`=0.
- **Saturation:** CNT_W=2, 5 ops with status 1000 → `cnt_inx` stops at 3.
- **LATENCY=1:** back-to-back ops with `res_ready` held high → `res_valid` one cycle per op and accepts spaced 3 cycles apart.

Source files
------------

// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the FPU operation sequencer.
//   state_t        : sequencer FSM states (IDLE / WAIT / RESULT)
//   STAT_*         : bit positions inside the one-hot FPU status word
//   DEF_LATENCY    : default number of cycles the FPU needs with stable operands
//   DEF_CNT_W      : default width of the status event counters
package fpu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam int STAT_EXACT     = 0;
  localparam int STAT_OVERFLOW  = 1;
  localparam int STAT_UNDERFLOW = 2;
  localparam int STAT_INEXACT   = 3;

  localparam int DEF_LATENCY = 4;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset, clears the count
//   inc     : add one this cycle (ignored once the count is all-ones)
//   clr     : synchronous clear, wins over a same-cycle inc
//   o_cnt   : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fpu_op_sequencer.sv
// Control stage wrapped around the FPU datapath. Accepts one operand pair at
// a time, holds it on the FPU operand inputs for LATENCY cycles, captures the
// FPU result/status/flag and offers them downstream. Keeps saturating counters
// of overflow, underflow and inexact results.
//   clock100KHz / reset        : clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b: operand handshake
//   op_A_out/op_B_out          : operands to the FPU
//   fpu_data_in/status/flags   : FPU outputs
//   res_valid/res_ready/res_*  : result handshake
//   busy                       : FSM not in IDLE
//   cnt_clr, cnt_ovf/unf/inx   : event counter clear and values
module fpu_op_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clock100KHz,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      op_A_out,
  output logic [31:0]      op_B_out,
  input  logic [31:0]      fpu_data_in,
  input  logic [3:0]       fpu_status_in,
  input  logic             fpu_flags_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [3:0]       res_status,
  output logic             res_flag,
  output logic             busy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_ovf,
  output logic [CNT_W-1:0] cnt_unf,
  output logic [CNT_W-1:0] cnt_inx
);

  // Wait counter must hold the value LATENCY itself.
  localparam int WCW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [WCW-1:0] LAT_LOAD = WCW'(LATENCY);
  localparam logic [WCW-1:0] LAT_LAST = WCW'(1);

  state_t         r_state;
  state_t         w_state_next;
  logic [WCW-1:0] r_wait_cnt;
  logic [WCW-1:0] w_wait_cnt_next;
  logic           w_in_fire;
  logic           w_capture;

  logic [31:0]    r_op_a;
  logic [31:0]    r_op_b;
  logic [31:0]    r_res_data;
  logic [3:0]     r_res_status;
  logic           r_res_flag;

  // State register
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_in_fire       = 1'b0;
    w_capture       = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_in_fire       = 1'b1;
          w_wait_cnt_next = LAT_LOAD;
          w_state_next    = WAIT;
        end
      end
      WAIT: begin
        w_wait_cnt_next = r_wait_cnt - 1'b1;
        // Counter value 1 marks the LATENCY-th edge after acceptance.
        if (r_wait_cnt == LAT_LAST) begin
          w_capture    = 1'b1;
          w_state_next = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Operand and result registers
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_res_data   <= '0;
      r_res_status <= '0;
      r_res_flag   <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_op_a <= in_a;
        r_op_b <= in_b;
      end
      if (w_capture) begin
        r_res_data   <= fpu_data_in;
        r_res_status <= fpu_status_in;
        r_res_flag   <= fpu_flags_in;
      end
    end
  end

  // in_ready is forced low while reset is held so every output reads 0.
  assign in_ready   = (r_state == IDLE) && reset;
  assign busy       = (r_state != IDLE);
  assign res_valid  = (r_state == RESULT);
  assign op_A_out   = r_op_a;
  assign op_B_out   = r_op_b;
  assign res_data   = r_res_data;
  assign res_status = r_res_status;
  assign res_flag   = r_res_flag;

  // Event counters: overflow, underflow, inexact (in that order).
  localparam int CNT_BIT [3] = '{STAT_OVERFLOW, STAT_UNDERFLOW, STAT_INEXACT};
  logic [CNT_W-1:0] w_cnt [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      sat_counter #(
        .W (CNT_W)
      ) u_cnt (
        .i_clk   (clock100KHz),
        .i_rst_n (reset),
        .inc     (w_capture && fpu_status_in[CNT_BIT[gi]]),
        .clr     (cnt_clr),
        .o_cnt   (w_cnt[gi])
      );
    end
  endgenerate

  assign cnt_ovf = w_cnt[0];
  assign cnt_unf = w_cnt[1];
  assign cnt_inx = w_cnt[2];

endmodule

// File: tb/tb_fpu_op_sequencer.sv
`timescale 1ns/1ps
module tb_fpu_op_sequencer;

  localparam int L_A = 4;
  localparam int L_B = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        f;
    int          rise;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Instance A: LATENCY=4, CNT_W=16
  logic        iv_a, ir_a, rv_a, rr_a, rf_a, busy_a, ff_a, clr_a;
  logic [31:0] ia_a, ib_a, oa_a, ob_a, fd_a, rd_a;
  logic [3:0]  fs_a, rs_a;
  logic [15:0] co_a, cu_a, ci_a;

  // Instance B: LATENCY=1, CNT_W=2
  logic        iv_b, ir_b, rv_b, rr_b, rf_b, busy_b, ff_b, clr_b;
  logic [31:0] ia_b, ib_b, oa_b, ob_b, fd_b, rd_b;
  logic [3:0]  fs_b, rs_b;
  logic [1:0]  co_b, cu_b, ci_b;

  fpu_op_sequencer #(.LATENCY(L_A), .CNT_W(16)) dut_a (
    .clock100KHz(clk), .reset(rst_n),
    .in_valid(iv_a), .in_ready(ir_a), .in_a(ia_a), .in_b(ib_a),
    .op_A_out(oa_a), .op_B_out(ob_a),
    .fpu_data_in(fd_a), .fpu_status_in(fs_a), .fpu_flags_in(ff_a),
    .res_valid(rv_a), .res_ready(rr_a), .res_data(rd_a), .res_status(rs_a), .res_flag(rf_a),
    .busy(busy_a), .cnt_clr(clr_a), .cnt_ovf(co_a), .cnt_unf(cu_a), .cnt_inx(ci_a)
  );

  fpu_op_sequencer #(.LATENCY(L_B), .CNT_W(2)) dut_b (
    .clock100KHz(clk), .reset(rst_n),
    .in_valid(iv_b), .in_ready(ir_b), .in_a(ia_b), .in_b(ib_b),
    .op_A_out(oa_b), .op_B_out(ob_b),
    .fpu_data_in(fd_b), .fpu_status_in(fs_b), .fpu_flags_in(ff_b),
    .res_valid(rv_b), .res_ready(rr_b), .res_data(rd_b), .res_status(rs_b), .res_flag(rf_b),
    .busy(busy_b), .cnt_clr(clr_b), .cnt_ovf(co_b), .cnt_unf(cu_b), .cnt_inx(ci_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Called at a negedge; returns the edge index at which the pair was accepted.
  task automatic offer_a(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                         input logic [3:0] s, input logic f, input bit push, output int acc);
    int n = 0;
    iv_a = 1'b1; ia_a = a; ib_a = b;
    while (!ir_a && n < 100) begin @(negedge clk); n++; end
    chk("accept_ready_a", ir_a, 1'b1);
    fd_a = d; fs_a = s; ff_a = f;
    acc = cyc + 1;
    if (push) q_a.push_back('{d, s, f, acc + L_A});
    @(negedge clk);
    iv_a = 1'b0;
    chk("op_a_after_accept_a", oa_a, a);
    chk("op_b_after_accept_a", ob_a, b);
    chk("busy_in_wait_a", {busy_a, ir_a}, 2'b10);
  endtask

  task automatic offer_b(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                         input logic [3:0] s, input logic f, output int acc);
    int n = 0;
    iv_b = 1'b1; ia_b = a; ib_b = b;
    while (!ir_b && n < 100) begin @(negedge clk); n++; end
    chk("accept_ready_b", ir_b, 1'b1);
    fd_b = d; fs_b = s; ff_b = f;
    acc = cyc + 1;
    q_b.push_back('{d, s, f, acc + L_B});
    @(negedge clk);
    iv_b = 1'b0;
    chk("op_a_after_accept_b", oa_b, a);
    chk("busy_in_wait_b", {busy_b, ir_b}, 2'b10);
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while ((q_a.size() != 0 || !ir_a) && n < 200) begin @(negedge clk); n++; end
    chk("idle_queue_a", q_a.size(), 0);
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while ((q_b.size() != 0 || !ir_b) && n < 200) begin @(negedge clk); n++; end
    chk("idle_queue_b", q_b.size(), 0);
  endtask

  // Monitors: pop and compare on each result handshake.
  int   rise_a = 0, rise_b = 0, vcount_b = 0;
  logic pv_a = 1'b0, pv_b = 1'b0;

  always begin
    exp_t e;
    @(negedge clk); #1;
    if (rv_a && !pv_a) rise_a = cyc;
    if (rv_a && rr_a) begin
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result_a actual=%h required=none", rd_a);
      end else begin
        e = q_a.pop_front();
        $display("txn a: data=%h status=%b flag=%b rise=%0d", rd_a, rs_a, rf_a, rise_a);
        chk("res_data_a", rd_a, e.d);
        chk("res_status_a", rs_a, e.s);
        chk("res_flag_a", rf_a, e.f);
        chk("res_rise_cycle_a", rise_a, e.rise);
      end
    end
    pv_a = rv_a;
  end

  always begin
    exp_t e;
    @(negedge clk); #1;
    if (rv_b) vcount_b++;
    if (rv_b && !pv_b) rise_b = cyc;
    if (rv_b && rr_b) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result_b actual=%h required=none", rd_b);
      end else begin
        e = q_b.pop_front();
        $display("txn b: data=%h status=%b flag=%b rise=%0d", rd_b, rs_b, rf_b, rise_b);
        chk("res_data_b", rd_b, e.d);
        chk("res_status_b", rs_b, e.s);
        chk("res_flag_b", rf_b, e.f);
        chk("res_rise_cycle_b", rise_b, e.rise);
      end
    end
    pv_b = rv_b;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc_b [5];
    logic [31:0] hd;
    logic [3:0]  hs;
    logic        hf;
    bit stable, saw_valid;
    int n;

    iv_a = 0; ia_a = 0; ib_a = 0; fd_a = 0; fs_a = 0; ff_a = 0; rr_a = 0; clr_a = 0;
    iv_b = 0; ia_b = 0; ib_b = 0; fd_b = 0; fs_b = 0; ff_b = 0; rr_b = 0; clr_b = 0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset_ops_a", {oa_a, ob_a}, 64'h0);
    chk("reset_res_a", {rv_a, rd_a, rs_a, rf_a, busy_a}, 39'h0);
    chk("reset_cnts_a", {co_a, cu_a, ci_a}, 48'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset_a", {ir_a, busy_a}, 2'b10);

    // Basic op
    rr_a = 1'b1;
    offer_a(32'h3FC00000, 32'h40100000, 32'h40700000, 4'b0001, 1'b0, 1, acc);
    wait_idle_a();
    chk("basic_cnts_a", {co_a, cu_a, ci_a}, 48'h0);

    // Backpressure, zero status passes through
    rr_a = 1'b0;
    offer_a(32'h40490FDB, 32'h3F800000, 32'hC0000000, 4'b0000, 1'b1, 1, acc);
    n = 0;
    while (!rv_a && n < 20) begin @(negedge clk); n++; end
    chk("bp_valid_a", rv_a, 1'b1);
    hd = rd_a; hs = rs_a; hf = rf_a;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      iv_a = (i % 2 == 0); ia_a = 32'hDEADBEEF; ib_a = 32'hCAFEF00D;
      fd_a = 32'h12345678; fs_a = 4'b1111; ff_a = 1'b0;
      @(negedge clk);
      if (rd_a !== hd || rs_a !== hs || rf_a !== hf || ir_a !== 1'b0 || rv_a !== 1'b1) stable = 0;
    end
    iv_a = 1'b0;
    chk("bp_stable_a", stable, 1'b1);
    chk("bp_ops_held_a", {oa_a, ob_a}, {32'h40490FDB, 32'h3F800000});
    rr_a = 1'b1;
    @(negedge clk);
    chk("bp_ready_after_hs_a", {ir_a, rv_a}, 2'b10);
    wait_idle_a();

    // Counters: 3x overflow, 1x underflow+inexact
    for (int k = 0; k < 3; k++) begin
      offer_a(32'h7F000000 + 32'(k), 32'h7F000000, 32'h7F800000, 4'b0010, 1'b1, 1, acc);
      wait_idle_a();
    end
    offer_a(32'h00800000, 32'h00000003, 32'h00000001, 4'b1100, 1'b1, 1, acc);
    wait_idle_a();
    chk("cnt_ovf_a", co_a, 16'd3);
    chk("cnt_unf_a", cu_a, 16'd1);
    chk("cnt_inx_a", ci_a, 16'd1);

    // Reset mid-WAIT discards the in-flight op
    offer_a(32'h11111111, 32'h22222222, 32'h33333333, 4'b1110, 1'b0, 0, acc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstw_ops_a", {oa_a, ob_a}, 64'h0);
    chk("rstw_res_a", {rv_a, rd_a, rs_a, rf_a, busy_a}, 39'h0);
    chk("rstw_cnts_a", {co_a, cu_a, ci_a}, 48'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstw_ready_a", {ir_a, busy_a}, 2'b10);
    saw_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rv_a) saw_valid = 1;
    end
    chk("rstw_no_result_a", saw_valid, 1'b0);

    // cnt_clr on the capture cycle wins over the increment
    offer_a(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0010, 1'b1, 1, acc);
    wait_idle_a();
    chk("cnt_ovf_before_clr_a", co_a, 16'd1);
    offer_a(32'h7F7FFFFF, 32'h40400000, 32'h7F800000, 4'b0010, 1'b1, 1, acc);
    while (cyc < acc + L_A - 1) @(negedge clk);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("cnt_clr_wins_a", co_a, 16'd0);
    wait_idle_a();

    // LATENCY=1, back-to-back, CNT_W=2 saturation
    rr_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      offer_b(32'(k), ~32'(k), 32'h3F800000 + 32'(k), 4'b1000, k[0], acc_b[k]);
    end
    iv_b = 1'b0;
    wait_idle_b();
    chk("cnt_inx_sat_b", ci_b, 2'd3);
    chk("cnt_ovf_b", co_b, 2'd0);
    for (int k = 1; k < 5; k++) begin
      chk("accept_spacing_b", acc_b[k] - acc_b[k-1], 3);
    end
    chk("valid_cycles_b", vcount_b, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
